// File: rtl/cosim_chan_bridge_if.sv
// Stream-side bundle of the co-simulation bridge: monitored inputs, export event stream,
// import command stream and driven outputs.
interface cosim_chan_bridge_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 16
);
  localparam int CW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] mon_data;
  logic                      exp_valid;
  logic                      exp_ready;
  logic [CW-1:0]             exp_chan;
  logic [WIDTH-1:0]          exp_data;
  logic [CNT_W-1:0]          exp_time;
  logic                      exp_overflow;
  logic                      imp_valid;
  logic                      imp_ready;
  logic [CW-1:0]             imp_chan;
  logic [WIDTH-1:0]          imp_data;
  logic [CNT_W-1:0]          imp_delay;
  logic                      imp_err;
  logic [CHANNELS*WIDTH-1:0] drv_data;
  logic [CHANNELS-1:0]       drv_update;

  modport master (
    input  mon_data, exp_ready, imp_valid, imp_chan, imp_data, imp_delay,
    output exp_valid, exp_chan, exp_data, exp_time, exp_overflow,
    output imp_ready, imp_err, drv_data, drv_update
  );

  modport slave (
    output mon_data, exp_ready, imp_valid, imp_chan, imp_data, imp_delay,
    input  exp_valid, exp_chan, exp_data, exp_time, exp_overflow,
    input  imp_ready, imp_err, drv_data, drv_update
  );
endinterface

// File: rtl/cosim_chan_bridge.sv
// Co-simulation bridge: exports timestamped channel value changes through a show-ahead
// FIFO and applies host import commands to driven channels after a cycle delay.
module cosim_chan_bridge #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cosim_chan_bridge_if.master bus
);
  localparam int CW = $clog2(CHANNELS);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + WIDTH + CNT_W;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} imp_state_t;

  logic [CNT_W-1:0]          tcnt_r;
  logic                      init_r;
  logic [CHANNELS*WIDTH-1:0] prev_r;
  logic [CHANNELS-1:0]       pending_r;
  logic [CW-1:0]             rr_ptr_r;
  logic                      overflow_r;
  logic [CHANNELS-1:0]       changed_s;
  logic [CHANNELS-1:0]       grant_s;
  logic                      grant_any_s;
  logic [CW-1:0]             grant_idx_s;
  logic [CW-1:0]             cand_s;
  logic [CW-1:0]             rr_next_s;
  logic [WIDTH-1:0]          sel_data_s;

  logic [EW-1:0]             mem_r [DEPTH];
  logic [AW-1:0]             wr_ptr_r;
  logic [AW-1:0]             rd_ptr_r;
  logic [AW:0]               count_r;
  logic                      full_s;
  logic                      valid_s;
  logic                      pop_s;
  logic [EW-1:0]             head_s;

  imp_state_t                state_r;
  imp_state_t                state_next_s;
  logic [CW-1:0]             chan_r;
  logic [WIDTH-1:0]          data_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      imp_ready_s;
  logic                      accept_s;
  logic                      fire_s;
  logic                      chan_ok_s;
  logic [CHANNELS*WIDTH-1:0] drv_data_r;
  logic [CHANNELS-1:0]       drv_update_r;
  logic                      imp_err_r;

  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign valid_s   = (count_r != '0);
  assign pop_s     = valid_s & bus.exp_ready;
  assign head_s    = mem_r[rd_ptr_r];
  assign chan_ok_s = (int'(chan_r) < CHANNELS);

  // Per-channel change detection against the previous edge's sample
  always_comb begin
    changed_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.mon_data[i*WIDTH +: WIDTH] != prev_r[i*WIDTH +: WIDTH]) begin
        changed_s[i] = 1'b1;
      end else begin
        changed_s[i] = 1'b0;
      end
    end
  end

  // Round-robin pick of the first pending channel at or after rr_ptr, only when FIFO has room
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    grant_s     = '0;
    sel_data_s  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand_s = CW'((int'(rr_ptr_r) + k) % CHANNELS);
      if (!grant_any_s && !full_s && pending_r[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (CW'(i) == grant_idx_s) begin
        sel_data_s = bus.mon_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    rr_next_s = CW'((int'(grant_idx_s) + 1) % CHANNELS);
  end

  // Timestamp, pending set and sticky overflow; the first edge after reset only seeds prev
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r     <= '0;
      init_r     <= 1'b1;
      prev_r     <= '0;
      pending_r  <= '0;
      rr_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else begin
      tcnt_r <= tcnt_r + CNT_W'(1);
      prev_r <= bus.mon_data;
      if (init_r) begin
        init_r    <= 1'b0;
        pending_r <= '1;
      end else begin
        pending_r <= (pending_r | changed_s) & ~grant_s;
        if (grant_any_s) rr_ptr_r <= rr_next_s;
        if (|(changed_s & pending_r & ~grant_s)) overflow_r <= 1'b1;
      end
    end
  end

  // Export event FIFO; entries hold {chan, value, pre-edge timestamp}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (grant_any_s) begin
        mem_r[wr_ptr_r] <= {grant_idx_s, sel_data_s, tcnt_r};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({grant_any_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Import FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Import FSM next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.imp_valid) state_next_s = ST_WAIT;
        else               state_next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == '0) state_next_s = ST_IDLE;
        else             state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Import FSM outputs: accept in IDLE, fire when the delay has run out
  always_comb begin
    imp_ready_s = 1'b0;
    accept_s    = 1'b0;
    fire_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        imp_ready_s = 1'b1;
        accept_s    = bus.imp_valid;
      end
      ST_WAIT: begin
        if (cnt_r == '0) fire_s = 1'b1;
        else             fire_s = 1'b0;
      end
      default: begin
        imp_ready_s = 1'b0;
        fire_s      = 1'b0;
      end
    endcase
  end

  // Command latch, delay countdown and driven-channel write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_r       <= '0;
      data_r       <= '0;
      cnt_r        <= '0;
      drv_data_r   <= '0;
      drv_update_r <= '0;
      imp_err_r    <= 1'b0;
    end else begin
      drv_update_r <= '0;
      if (accept_s) begin
        chan_r <= bus.imp_chan;
        data_r <= bus.imp_data;
        cnt_r  <= bus.imp_delay;
      end else if (state_r == ST_WAIT && !fire_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (fire_s) begin
        if (chan_ok_s) begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (CW'(i) == chan_r) begin
              drv_data_r[i*WIDTH +: WIDTH] <= data_r;
              drv_update_r[i]              <= 1'b1;
            end
          end
        end else begin
          imp_err_r <= 1'b1;
        end
      end
    end
  end

  assign bus.exp_valid    = valid_s;
  assign bus.exp_chan     = head_s[EW-1 -: CW];
  assign bus.exp_data     = head_s[CNT_W +: WIDTH];
  assign bus.exp_time     = head_s[CNT_W-1:0];
  assign bus.exp_overflow = overflow_r;
  assign bus.imp_ready    = imp_ready_s;
  assign bus.imp_err      = imp_err_r;
  assign bus.drv_data     = drv_data_r;
  assign bus.drv_update   = drv_update_r;
endmodule
